// File: rtl/tea_text_gen.sv
// tea_text_gen: LFSR plaintext source on an AXI4-Stream master with checker echo; TEA_TEXT_GEN_THROTTLE_EN adds pseudo-random idle gaps.
module tea_text_gen #(
  parameter logic [63:0] SEED  = 64'h0123_4567_89AB_CDEF,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_num,
  output logic [63:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [63:0]      textI,
  output logic             textI_vld,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [63:0] SEED_I = (SEED == 64'd0) ? 64'd1 : SEED;
  state_t state, state_n;
  logic [63:0] lfsr;
  logic [CNT_W-1:0] cfg_q;
  logic acc, hs, gap;
  assign acc = start & (state != RUN);
  assign m_axis_tvalid = (state == RUN) & ~gap;
  assign hs = m_axis_tvalid & m_axis_tready;
  assign m_axis_tlast = m_axis_tvalid & (sent_cnt == cfg_q - CNT_W'(1));
  assign m_axis_tdata = lfsr;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_n = acc ? ((cfg_num != '0) ? RUN : DONE)
            : (state == DONE) ? IDLE
            : (hs & m_axis_tlast) ? DONE : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= SEED_I;
      cfg_q     <= '0;
      sent_cnt  <= '0;
      textI     <= '0;
      textI_vld <= 1'b0;
    end else begin
      state     <= state_n;
      textI_vld <= hs;
      if (hs) textI <= lfsr;
      if (acc) begin
        lfsr     <= SEED_I;
        cfg_q    <= cfg_num;
        sent_cnt <= '0;
      end else if (hs) begin
        lfsr     <= {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
        sent_cnt <= sent_cnt + CNT_W'(1);
      end
    end
  end
`ifdef TEA_TEXT_GEN_THROTTLE_EN
  logic [7:0] thr;
  // A gap after the final beat would be pointless, so only mid-run beats can trigger one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr <= 8'hA5;
      gap <= 1'b0;
    end else begin
      thr <= acc ? 8'hA5 : (state == RUN) ? {thr[6:0], thr[7] ^ thr[5] ^ thr[4] ^ thr[3]} : thr;
      gap <= hs & thr[0] & ~m_axis_tlast & ~acc;
    end
  end
`else
  assign gap = 1'b0;
`endif
endmodule

// File: tb/tb_tea_text_gen.sv
// tb_tea_text_gen: directed checks of the tea_text_gen stream, echo, run control and reset abort.
module tb_tea_text_gen;
  logic clk = 0, reset = 1, start = 0, tready = 0;
  logic [15:0] cfg_num = 0, sent_cnt;
  logic [63:0] tdata, textI;
  logic tvalid, tlast, textI_vld, busy, done;
  int tests = 0, fails = 0;
  logic [63:0] w [8] = '{64'h0123456789ABCDEF, 64'h02468ACF13579BDE, 64'h048D159E26AF37BC,
                         64'h091A2B3C4D5E6F78, 64'h123456789ABCDEF1, 64'h2468ACF13579BDE3,
                         64'h48D159E26AF37BC6, 64'h91A2B3C4D5E6F78C};

  tea_text_gen dut (
    .clk(clk), .reset(reset), .start(start), .cfg_num(cfg_num),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .textI(textI), .textI_vld(textI_vld),
    .busy(busy), .done(done), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task start_run(input logic [15:0] n);
    cfg_num = n;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task test_reset;
    @(negedge clk);
    tests++;
    if (tvalid !== 0 || busy !== 0 || done !== 0 || sent_cnt !== 0 || textI_vld !== 0 || textI !== 0 || tlast !== 0) begin
      fails++;
      $display("FAIL reset: valid=%b busy=%b done=%b cnt=%0d tvld=%b textI=%h last=%b, want all 0", tvalid, busy, done, sent_cnt, textI_vld, textI, tlast);
    end
    reset = 0;
    @(negedge clk);
  endtask

  task test_basic;
    tready = 1;
    start_run(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (tvalid !== 1 || tdata !== w[i] || tlast !== (i == 3) || busy !== 1) begin
        fails++;
        $display("FAIL basic beat%0d: valid=%b data=%h last=%b busy=%b, want 1 %h %b 1", i, tvalid, tdata, tlast, busy, w[i], i == 3);
      end
      if (i > 0) begin
        tests++;
        if (textI_vld !== 1 || textI !== w[i-1]) begin
          fails++;
          $display("FAIL basic echo%0d: vld=%b textI=%h, want 1 %h", i - 1, textI_vld, textI, w[i-1]);
        end
      end
      @(negedge clk);
    end
    tests++;
    if (tvalid !== 0 || done !== 1 || busy !== 0 || sent_cnt !== 4 || textI_vld !== 1 || textI !== w[3]) begin
      fails++;
      $display("FAIL basic end: valid=%b done=%b busy=%b cnt=%0d vld=%b textI=%h, want 0 1 0 4 1 %h", tvalid, done, busy, sent_cnt, textI_vld, textI, w[3]);
    end
    @(negedge clk);
    tests++;
    if (done !== 0 || textI_vld !== 0 || sent_cnt !== 4) begin
      fails++;
      $display("FAIL basic idle: done=%b vld=%b cnt=%0d, want 0 0 4", done, textI_vld, sent_cnt);
    end
  endtask

  task test_stall;
    int k;
    k = 0;
    tready = 0;
    start_run(3);
    for (int c = 0; c < 20 && k < 3; c++) begin
      tests++;
      if (tvalid !== 1 || tdata !== w[k] || tlast !== (k == 2)) begin
        fails++;
        $display("FAIL stall cyc%0d: valid=%b data=%h last=%b, want 1 %h %b", c, tvalid, tdata, tlast, w[k], k == 2);
      end
      tready = c[0];
      if (tready) k++;
      @(negedge clk);
    end
    tests++;
    if (k != 3) begin
      fails++;
      $display("FAIL stall timeout: beats=%0d, want 3", k);
    end
    tests++;
    if (tvalid !== 0 || done !== 1 || sent_cnt !== 3) begin
      fails++;
      $display("FAIL stall end: valid=%b done=%b cnt=%0d, want 0 1 3", tvalid, done, sent_cnt);
    end
    tready = 1;
    @(negedge clk);
  endtask

  task test_zero;
    int dn;
    dn = 0;
    start_run(0);
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (tvalid !== 0) begin
        fails++;
        $display("FAIL zero valid cyc%0d: valid=%b, want 0", c, tvalid);
      end
      dn += done;
      @(negedge clk);
    end
    tests++;
    if (dn != 1 || sent_cnt !== 0) begin
      fails++;
      $display("FAIL zero done: pulses=%0d cnt=%0d, want 1 0", dn, sent_cnt);
    end
  endtask

  task test_restart_ignored;
    int dn;
    dn = 0;
    tready = 1;
    start_run(8);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (tvalid !== 1 || tdata !== w[i] || tlast !== (i == 7)) begin
        fails++;
        $display("FAIL restart beat%0d: valid=%b data=%h last=%b, want 1 %h %b", i, tvalid, tdata, tlast, w[i], i == 7);
      end
      start = (i == 2);
      if (i == 2) cfg_num = 2;
      @(negedge clk);
    end
    tests++;
    if (done !== 1 || sent_cnt !== 8 || tvalid !== 0) begin
      fails++;
      $display("FAIL restart end: done=%b cnt=%0d valid=%b, want 1 8 0", done, sent_cnt, tvalid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dn += done;
    end
    tests++;
    if (dn != 0) begin
      fails++;
      $display("FAIL restart extra done: pulses=%0d, want 0", dn);
    end
  endtask

  task test_reset_abort;
    int dn;
    dn = 0;
    tready = 1;
    start_run(6);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (tvalid !== 1 || tdata !== w[2]) begin
      fails++;
      $display("FAIL abort pre: valid=%b data=%h, want 1 %h", tvalid, tdata, w[2]);
    end
    #1 reset = 1;
    #1;
    tests++;
    if (tvalid !== 0 || busy !== 0) begin
      fails++;
      $display("FAIL abort async: valid=%b busy=%b, want 0 0", tvalid, busy);
    end
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      dn += done;
      tests++;
      if (tvalid !== 0 || busy !== 0) begin
        fails++;
        $display("FAIL abort idle cyc%0d: valid=%b busy=%b, want 0 0", c, tvalid, busy);
      end
      @(negedge clk);
    end
    tests++;
    if (dn != 0) begin
      fails++;
      $display("FAIL abort done: pulses=%0d, want 0", dn);
    end
    start_run(2);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (tvalid !== 1 || tdata !== w[i] || tlast !== (i == 1)) begin
        fails++;
        $display("FAIL abort rerun beat%0d: valid=%b data=%h last=%b, want 1 %h %b", i, tvalid, tdata, tlast, w[i], i == 1);
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1 || sent_cnt !== 2) begin
      fails++;
      $display("FAIL abort rerun end: done=%b cnt=%0d, want 1 2", done, sent_cnt);
    end
    @(negedge clk);
  endtask

`ifdef TEA_TEXT_GEN_THROTTLE_EN
  function automatic logic [63:0] step(input logic [63:0] c);
    return {c[62:0], c[63] ^ c[62] ^ c[60] ^ c[59]};
  endfunction

  task test_throttle;
    logic [63:0] m;
    int k;
    m = w[0];
    k = 0;
    tready = 1;
    start_run(16);
    for (int c = 0; c < 64 && k < 16; c++) begin
      if (tvalid) begin
        tests++;
        if (tdata !== m || tlast !== (k == 15)) begin
          fails++;
          $display("FAIL throttle beat%0d: data=%h last=%b, want %h %b", k, tdata, tlast, m, k == 15);
        end
        m = step(m);
        k++;
      end
      @(negedge clk);
    end
    tests++;
    if (k != 16 || done !== 1) begin
      fails++;
      $display("FAIL throttle end: beats=%0d done=%b, want 16 1", k, done);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_zero;
    test_restart_ignored;
    test_reset_abort;
`ifdef TEA_TEXT_GEN_THROTTLE_EN
    test_throttle;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
